// File: rtl/fetch_pkg.sv
// fetch_pkg: shared width, NOP encoding, FSM state and FIFO entry types for instr_fetch_buffer (rev 1.0)
`default_nettype none

package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DROP      = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: PC, imem and decode bundle; FETCH_MISALIGN_CHECK_EN adds fetch_misalign_o (rev 1.0)
`default_nettype none

interface instr_fetch_buffer_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] pc_i;
  logic            pc_adv_o;
  logic            flush_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            dec_valid_o;
  logic [XLEN-1:0] dec_pc_o;
  logic [XLEN-1:0] dec_instr_o;
  logic            dec_ready_i;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            fetch_misalign_o;

  modport slave (
    input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
    output pc_adv_o, imem_req_o, imem_addr_o, dec_valid_o, dec_pc_o, dec_instr_o,
           fetch_misalign_o
  );
  modport master (
    output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
    input  pc_adv_o, imem_req_o, imem_addr_o, dec_valid_o, dec_pc_o, dec_instr_o,
           fetch_misalign_o
  );
`else
  modport slave (
    input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
    output pc_adv_o, imem_req_o, imem_addr_o, dec_valid_o, dec_pc_o, dec_instr_o
  );
  modport master (
    output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, dec_ready_i,
    input  pc_adv_o, imem_req_o, imem_addr_o, dec_valid_o, dec_pc_o, dec_instr_o
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular {pc, instr, misalign} queue with clear; head is zero while empty (rev 1.0)
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  fetch_entry_t             i_entry,
  input  logic                     i_pop,
  output logic                     o_valid,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != (PTR_W+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by o_valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: single-outstanding imem fetch FSM feeding a decode FIFO, with flush/redirect;
// FETCH_MISALIGN_CHECK_EN pushes a NOP for unaligned PCs instead of fetching (rev 1.0)
`default_nettype none

module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_buffer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            w_req, w_adv, w_push, w_aligned;
  logic            w_dec_valid, w_pop_fire, w_credit_idle, w_credit_next;
  fetch_entry_t    w_entry, w_head;
  logic [CNT_W-1:0] w_count;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_aligned = (bus.pc_i[1:0] == 2'b00);
`else
  assign w_aligned = 1'b1;
`endif

  assign w_pop_fire    = w_dec_valid && bus.dec_ready_i;
  assign w_credit_idle = (w_count < CNT_W'(DEPTH));
  // Credit as it will stand once this cycle's response has been pushed.
  assign w_credit_next = w_pop_fire ? w_credit_idle : (w_count < CNT_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_req          = 1'b0;
    w_adv          = 1'b0;
    w_push         = 1'b0;
    w_entry.pc       = r_addr;
    w_entry.instr    = bus.imem_rdata_i;
    w_entry.misalign = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_credit_idle && !bus.flush_i) begin
          if (w_aligned) begin
            w_state_nxt = REQ;
            w_addr_nxt  = bus.pc_i;
          end else begin
            w_push           = 1'b1;
            w_adv            = 1'b1;
            w_entry.pc       = bus.pc_i;
            w_entry.instr    = NOP_INSTR;
            w_entry.misalign = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.flush_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_req = 1'b1;
          if (bus.imem_gnt_i) begin
            w_adv       = 1'b1;
            w_state_nxt = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (bus.imem_rvalid_i) begin
          if (bus.flush_i) begin
            w_state_nxt = IDLE;
          end else begin
            w_push = 1'b1;
            if (w_credit_next && w_aligned) begin
              w_state_nxt = REQ;
              w_addr_nxt  = bus.pc_i;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end else if (bus.flush_i) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (bus.imem_rvalid_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (bus.flush_i),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (bus.dec_ready_i),
    .o_valid (w_dec_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_req_o  = w_req;
  assign bus.pc_adv_o    = w_adv;
  assign bus.imem_addr_o = r_addr;
  assign bus.dec_valid_o = w_dec_valid;
  assign bus.dec_pc_o    = w_head.pc;
  assign bus.dec_instr_o = w_head.instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.fetch_misalign_o = w_head.misalign;
`else
  logic w_unused_misalign;
  assign w_unused_misalign = w_head.misalign;
`endif

endmodule

`default_nettype wire

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
Fetch stage directly downstream of the program counter register. Consumes the current PC, issues one instruction-memory read at a time, and queues {pc, instr} pairs in a small FIFO for decode. Drives pc_adv back to the PC stage so the PC register steps only when a fetch is accepted. Discards stale work on a branch/jump redirect (flush).

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 4, FIFO entries; power of two, minimum 2
NOP_INSTR, 32'h0000_0013, instruction pushed for faulting fetches (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_i  input  XLEN  current PC from program counter register
pc_adv_o  output  1  one-cycle pulse: PC stage loads PCNext this edge
flush_i  input  1  redirect from execute; kill queued and in-flight fetches
imem_req_o  output  1  read request valid
imem_addr_o  output  XLEN  read address (equals pc_i latched at request)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid
imem_rdata_i  input  XLEN  read data
dec_valid_o  output  1  FIFO head valid
dec_pc_o  output  XLEN  PC of head entry
dec_instr_o  output  XLEN  instruction of head entry
dec_ready_i  input  1  decode pops head when dec_valid_o && dec_ready_i

Behaviour:
- Reset (async, rst_n low): state IDLE, FIFO empty, count 0; imem_req_o=0, imem_addr_o=0, pc_adv_o=0, dec_valid_o=0, dec_pc_o=0, dec_instr_o=0.
- Credit: request may start only if (fifo_count + inflight) < DEPTH; inflight is 1 in REQ/WAIT_RESP.
- FSM states: IDLE, REQ, WAIT_RESP, DROP.
- IDLE: if credit && !flush_i -> latch imem_addr_o=pc_i, go REQ.
- REQ: imem_req_o=1, address stable until grant. On imem_gnt_i: pc_adv_o=1 that cycle, go WAIT_RESP. flush_i in REQ (grant or not): drop request, pc_adv_o=0, go IDLE.
- WAIT_RESP: on imem_rvalid_i push {imem_addr_o, imem_rdata_i}, go IDLE (or REQ directly if credit after push). flush_i without rvalid -> DROP. flush_i with rvalid same cycle -> response discarded, go IDLE.
- DROP: await imem_rvalid_i, discard data, go IDLE. No new request until response drained.
- Latency: grant to decode-visible = response cycle + 1 (FIFO registered output); best case 1 fetch per 2 cycles (IDLE->REQ->WAIT_RESP), back-to-back via WAIT_RESP->REQ.
- FIFO: circular, pointers wrap modulo DEPTH; simultaneous push and pop when full is legal only because credit prevents overflow; push+pop same cycle keeps count. Pop when empty ignored.
- flush_i: FIFO cleared same edge (count=0, pointers reset); dec_valid_o low next cycle; a push in the flush cycle is suppressed. Flush has priority over push and pop.
- imem_rvalid_i in IDLE/REQ is a protocol error: ignored.
- Widths: count is clog2(DEPTH)+1 bits; no arithmetic on PC inside block.

Optional Feature:
FETCH_MISALIGN_CHECK_EN: when defined, adds output fetch_misalign_o (1 bit, per FIFO entry, aligned with head). PC with pc_i[1:0]!=0 issues no imem request: entry {pc_i, NOP_INSTR, misalign=1} is pushed directly from IDLE (with credit), pc_adv_o pulses that cycle. Without the macro, low PC bits are ignored, request issued normally, port absent.

Decomposition:
- Shared package fetch_pkg: XLEN, NOP_INSTR, FSM state enum (IDLE/REQ/WAIT_RESP/DROP), fetch-entry struct {pc, instr, misalign}.
- One sub-module: fetch_fifo (parameterised DEPTH, synchronous push/pop, clear input, async active-low reset).

Test Plan:
- Reset mid-WAIT_RESP: rst_n low -> all outputs 0, state IDLE, late rvalid ignored after release.
- Straight-line: pc_i 0x00,0x04,0x08,0x0C, gnt same cycle, rvalid next cycle, dec_ready_i=1 -> decode sees pairs in order, pc_adv_o 4 pulses.
- Backpressure: dec_ready_i=0 -> exactly DEPTH=4 entries then imem_req_o stays 0; raise ready -> fetching resumes, no loss.
- Flush in WAIT_RESP: flush_i at pc 0x10 -> rvalid data discarded, FIFO empty, next request uses new pc_i=0x100.
- Flush with rvalid same cycle and full FIFO pop -> nothing pushed, dec_valid_o=0 next cycle.
- FETCH_MISALIGN_CHECK_EN defined, pc_i=0x06 -> no imem_req_o, entry {0x06, 0x00000013, misalign=1}.
